// File: rtl/sprite_compositor.sv
// -----------------------------------------------------------------------------
// sprite_compositor
//
// Pixel-pipeline stage that merges the fireboy and icegirl sprite layers with
// the background. It maps the winning palette index to 24-bit RGB two cycles
// after the coverage flags are presented, and reports one collision pulse per
// frame per character.
//
// Ports
//   Clk           pixel clock
//   Reset         synchronous, active-high reset
//   frame_clk     vsync-rate frame clock; a rising edge marks a frame boundary
//   de            display enable for pixel N (cycle N)
//   is_fireboy    fireboy covers pixel N (cycle N)
//   fireboy_data  fireboy palette index for pixel N (cycle N+1)
//   is_icegirl    icegirl covers pixel N (cycle N)
//   icegirl_data  icegirl palette index for pixel N (cycle N+1)
//   bg_data       background palette index for pixel N (cycle N+1)
//   is_water      pixel N is water, a hazard to fireboy (cycle N)
//   is_lava       pixel N is lava, a hazard to icegirl (cycle N)
//   Red/Green/Blue  colour of pixel N, valid from edge N+2
//   fireboy_hit   one-cycle pulse after a frame edge when fireboy touched water
//   icegirl_hit   one-cycle pulse after a frame edge when icegirl touched lava
//
// Optional feature macro: COMPOSITOR_FLASH_EN
//   When defined, a character that was hit blinks white on alternate frames
//   for FLASH_FRAMES frames.
//
// Palette: the 256-entry ROM is built by pal_entry(). PALETTE_FILE names the
// matching hex palette image kept alongside the design for external flows.
// -----------------------------------------------------------------------------
module sprite_compositor #(
  parameter logic [7:0] TRANSP_IDX   = 8'h00,
  parameter             PALETTE_FILE = "palette.txt",
  parameter logic [3:0] FLASH_FRAMES = 4'd8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       de,
  input  logic       is_fireboy,
  input  logic [7:0] fireboy_data,
  input  logic       is_icegirl,
  input  logic [7:0] icegirl_data,
  input  logic [7:0] bg_data,
  input  logic       is_water,
  input  logic       is_lava,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic       fireboy_hit,
  output logic       icegirl_hit
);

  // Palette contents: two named colours, everything else a simple ramp.
  function automatic logic [23:0] pal_entry(input logic [7:0] i);
    case (i)
      8'h05:   pal_entry = 24'hFF8000;
      8'h09:   pal_entry = 24'h00C0FF;
      default: pal_entry = {i, i ^ 8'hA5, ~i};
    endcase
  endfunction

  logic [23:0] pal_rom [256];

  genvar gi;
  generate
    for (gi = 0; gi < 256; gi++) begin : g_pal
      assign pal_rom[gi] = pal_entry(8'(gi));
    end
  endgenerate

  logic unused_cfg;
  assign unused_cfg = ^{PALETTE_FILE, FLASH_FRAMES};

  // Stage-1 registers: align the cycle-N flags with the cycle-N+1 data.
  logic de_d1_q, is_fb_d1_q, is_ig_d1_q, water_d1_q, lava_d1_q;

  // Frame boundary detector.
  logic fclk_dly_q, frame_edge_q;

  logic        fb_pend_q, ig_pend_q;
  logic        fb_hit_q, ig_hit_q;
  logic [23:0] rgb_q, rgb_d;

  logic       fb_op, ig_op, fb_set_now, ig_set_now;
  logic       fb_sel, ig_sel;
  logic [7:0] sel_idx;
  logic       fb_white, ig_white;

  always_comb begin
    fb_op      = is_fb_d1_q && (fireboy_data != TRANSP_IDX);
    ig_op      = is_ig_d1_q && (icegirl_data != TRANSP_IDX);
    fb_set_now = de_d1_q && fb_op && water_d1_q;
    ig_set_now = de_d1_q && ig_op && lava_d1_q;
    fb_sel     = fb_op;
    ig_sel     = !fb_op && ig_op;
    if (fb_sel)      sel_idx = fireboy_data;
    else if (ig_sel) sel_idx = icegirl_data;
    else             sel_idx = bg_data;
  end

`ifdef COMPOSITOR_FLASH_EN
  logic [3:0] fb_cnt_q, ig_cnt_q, fb_cnt_d, ig_cnt_d;

  // Counters reload on the edge that fires a pulse, otherwise count down
  // once per frame edge and stop at zero.
  always_comb begin
    fb_cnt_d = fb_cnt_q;
    ig_cnt_d = ig_cnt_q;
    if (frame_edge_q) begin
      if (fb_pend_q || fb_set_now) fb_cnt_d = FLASH_FRAMES;
      else if (fb_cnt_q != 4'd0)   fb_cnt_d = fb_cnt_q - 4'd1;
      if (ig_pend_q || ig_set_now) ig_cnt_d = FLASH_FRAMES;
      else if (ig_cnt_q != 4'd0)   ig_cnt_d = ig_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fb_cnt_q <= 4'd0;
      ig_cnt_q <= 4'd0;
    end else begin
      fb_cnt_q <= fb_cnt_d;
      ig_cnt_q <= ig_cnt_d;
    end
  end

  // Bit 0 set implies the counter is nonzero.
  assign fb_white = fb_sel && fb_cnt_q[0];
  assign ig_white = ig_sel && ig_cnt_q[0];
`else
  assign fb_white = 1'b0;
  assign ig_white = 1'b0;
`endif

  always_comb begin
    rgb_d = pal_rom[sel_idx];
    if (!de_d1_q)                rgb_d = 24'h000000;
    else if (fb_white || ig_white) rgb_d = 24'hFFFFFF;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      de_d1_q      <= 1'b0;
      is_fb_d1_q   <= 1'b0;
      is_ig_d1_q   <= 1'b0;
      water_d1_q   <= 1'b0;
      lava_d1_q    <= 1'b0;
      fclk_dly_q   <= 1'b0;
      frame_edge_q <= 1'b0;
      fb_pend_q    <= 1'b0;
      ig_pend_q    <= 1'b0;
      fb_hit_q     <= 1'b0;
      ig_hit_q     <= 1'b0;
      rgb_q        <= 24'h000000;
    end else begin
      de_d1_q      <= de;
      is_fb_d1_q   <= is_fireboy;
      is_ig_d1_q   <= is_icegirl;
      water_d1_q   <= is_water;
      lava_d1_q    <= is_lava;
      fclk_dly_q   <= frame_clk;
      frame_edge_q <= frame_clk && !fclk_dly_q;
      rgb_q        <= rgb_d;
      if (frame_edge_q) begin
        // A collision on the edge cycle itself goes into this pulse.
        fb_hit_q  <= fb_pend_q | fb_set_now;
        ig_hit_q  <= ig_pend_q | ig_set_now;
        fb_pend_q <= 1'b0;
        ig_pend_q <= 1'b0;
      end else begin
        fb_hit_q <= 1'b0;
        ig_hit_q <= 1'b0;
        if (fb_set_now) fb_pend_q <= 1'b1;
        if (ig_set_now) ig_pend_q <= 1'b1;
      end
    end
  end

  assign {Red, Green, Blue} = rgb_q;
  assign fireboy_hit        = fb_hit_q;
  assign icegirl_hit        = ig_hit_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Testbench for sprite_compositor: directed pixels and frames with literal
// expectations, then randomized traffic checked every cycle against a model
// that derives each output from the recorded input history.
module tb_sprite_compositor;
  localparam int MAXC = 8192;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset, frame_clk, de, is_fireboy, is_icegirl, is_water, is_lava;
  logic [7:0] fireboy_data, icegirl_data, bg_data;
  wire  [7:0] Red, Green, Blue;
  wire        fireboy_hit, icegirl_hit;

  sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .de(de),
    .is_fireboy(is_fireboy), .fireboy_data(fireboy_data),
    .is_icegirl(is_icegirl), .icegirl_data(icegirl_data),
    .bg_data(bg_data), .is_water(is_water), .is_lava(is_lava),
    .Red(Red), .Green(Green), .Blue(Blue),
    .fireboy_hit(fireboy_hit), .icegirl_hit(icegirl_hit)
  );

  int tests = 0, fails = 0, cyc = 0;
  int fb_obs = 0, ig_obs = 0;

  // Input history, indexed by the cycle in which each value was presented.
  bit       h_rst[MAXC], h_de[MAXC], h_fb[MAXC], h_ig[MAXC];
  bit       h_w[MAXC], h_l[MAXC], h_fc[MAXC];
  bit [7:0] h_fbd[MAXC], h_igd[MAXC], h_bg[MAXC];

  // Model state: pending collisions and flash frame counters.
  bit m_fbp = 0, m_igp = 0;
  int m_fbc = 0, m_igc = 0;

  function automatic logic [23:0] pal(input logic [7:0] i);
    if (i == 8'h05)      return 24'hFF8000;
    else if (i == 8'h09) return 24'h00C0FF;
    else                 return {i, i ^ 8'hA5, ~i};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    h_rst[cyc] = Reset;     h_de[cyc] = de;        h_fb[cyc] = is_fireboy;
    h_ig[cyc]  = is_icegirl; h_w[cyc] = is_water;  h_l[cyc]  = is_lava;
    h_fc[cyc]  = frame_clk; h_fbd[cyc] = fireboy_data;
    h_igd[cyc] = icegirl_data; h_bg[cyc] = bg_data;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // Flags in cycle N, data in cycle N+1, colour checked in cycle N+2.
  task automatic pix(input bit f, input logic [7:0] fd, input bit i, input logic [7:0] id,
                     input logic [7:0] bd, input bit d, input bit w, input bit l,
                     input logic [23:0] exp, input string name, input bit chk);
    de = d; is_fireboy = f; is_icegirl = i; is_water = w; is_lava = l;
    tick();
    de = 0; is_fireboy = 0; is_icegirl = 0; is_water = 0; is_lava = 0;
    fireboy_data = fd; icegirl_data = id; bg_data = bd;
    tick();
    fireboy_data = 0; icegirl_data = 0; bg_data = 0;
    if (chk) check(name, {8'h00, Red, Green, Blue}, {8'h00, exp});
  endtask

  task automatic fedge();
    frame_clk = 1;
    repeat (3) tick();
    frame_clk = 0;
    repeat (3) tick();
  endtask

  // Per-cycle model: the output seen in cycle k comes from flags presented in
  // cycle k-2 and data presented in cycle k-1.
  always @(negedge Clk) begin
    int k;
    bit ra, rb, dv, fop, iop, cf, ci, fe, efh, eih, fsel, isel;
    logic [7:0]  idx;
    logic [23:0] erg;
    if (fireboy_hit === 1'b1) fb_obs++;
    if (icegirl_hit === 1'b1) ig_obs++;
    if (cyc >= 3 && cyc < MAXC) begin
      k    = cyc;
      ra   = h_rst[k-1];
      rb   = h_rst[k-2];
      dv   = h_de[k-2] && !rb;
      fop  = !rb && h_fb[k-2] && (h_fbd[k-1] != 8'h00);
      iop  = !rb && h_ig[k-2] && (h_igd[k-1] != 8'h00);
      fsel = fop;
      isel = !fop && iop;
      idx  = fsel ? h_fbd[k-1] : (isel ? h_igd[k-1] : h_bg[k-1]);
      erg  = pal(idx);
`ifdef COMPOSITOR_FLASH_EN
      if ((fsel && (m_fbc % 2 == 1)) || (isel && (m_igc % 2 == 1))) erg = 24'hFFFFFF;
`endif
      if (ra || !dv) erg = 24'h000000;
      efh = 0; eih = 0;
      if (ra) begin
        m_fbp = 0; m_igp = 0; m_fbc = 0; m_igc = 0;
      end else begin
        cf = dv && fop && h_w[k-2];
        ci = dv && iop && h_l[k-2];
        fe = !rb && h_fc[k-2] && !(h_fc[k-3] && !h_rst[k-3]);
        if (fe) begin
          efh = m_fbp || cf;
          eih = m_igp || ci;
          m_fbc = efh ? 8 : (m_fbc > 0 ? m_fbc - 1 : 0);
          m_igc = eih ? 8 : (m_igc > 0 ? m_igc - 1 : 0);
          m_fbp = 0; m_igp = 0;
        end else begin
          m_fbp = m_fbp || cf;
          m_igp = m_igp || ci;
        end
      end
      check("model_cycle", {6'b0, fireboy_hit, icegirl_hit, Red, Green, Blue},
            {6'b0, efh, eih, erg});
    end
  end

  initial begin
    int fb0, ig0;
    Reset = 1; frame_clk = 0; de = 1; is_fireboy = 1; is_icegirl = 1;
    is_water = 1; is_lava = 1; fireboy_data = 8'h05; icegirl_data = 8'h09; bg_data = 8'h11;

    // Reset with arbitrary inputs.
    repeat (4) begin
      tick();
      if (cyc >= 2) begin
        check("reset_rgb", {8'h00, Red, Green, Blue}, 32'h0);
        check("reset_hits", {30'b0, fireboy_hit, icegirl_hit}, 32'h0);
      end
    end
    Reset = 0; de = 0; is_fireboy = 0; is_icegirl = 0; is_water = 0; is_lava = 0;
    fireboy_data = 0; icegirl_data = 0; bg_data = 0;
    repeat (2) tick();

    // Priority and transparency.
    pix(1, 8'h05, 0, 8'h00, 8'h22, 1, 0, 0, 24'hFF8000, "fb_opaque", 1);
    pix(1, 8'h00, 1, 8'h09, 8'h22, 1, 0, 0, 24'h00C0FF, "fb_transp_ig", 1);
    pix(1, 8'h05, 1, 8'h09, 8'h22, 1, 0, 0, 24'hFF8000, "fb_over_ig", 1);
    pix(0, 8'h05, 1, 8'h00, 8'h00, 1, 0, 0, 24'h00A5FF, "bg_idx0", 1);
    pix(1, 8'h05, 0, 8'h00, 8'h22, 0, 0, 0, 24'h000000, "de_off", 1);

    // Blanked overlap must not collide.
    pix(1, 8'h05, 1, 8'h07, 8'h00, 0, 1, 1, 24'h000000, "de_off_hazard", 1);
    fedge();
    check("no_hit_blank_fb", fb_obs, 0);
    check("no_hit_blank_ig", ig_obs, 0);

    // One fireboy/water pixel mid-frame.
    repeat (5) tick();
    pix(1, 8'h05, 0, 8'h00, 8'h00, 1, 1, 0, 24'hFF8000, "fb_on_water", 1);
    repeat (5) tick();
    fedge();
    check("fb_hit_once", fb_obs, 1);
    check("ig_quiet", ig_obs, 0);
    fedge();
    check("fb_no_repeat", fb_obs, 1);

    // Icegirl/lava on the frame-edge cycle itself.
    ig0 = ig_obs;
    de = 1; is_icegirl = 1; is_lava = 1; frame_clk = 1;
    tick();
    de = 0; is_icegirl = 0; is_lava = 0; icegirl_data = 8'h33;
    tick();
    icegirl_data = 0;
    tick();
    frame_clk = 0;
    repeat (3) tick();
    check("ig_hit_on_edge", ig_obs, ig0 + 1);
    fedge();
    check("ig_no_repeat", ig_obs, ig0 + 1);

    // Reset between overlap and edge discards the hit.
    fb0 = fb_obs;
    de = 1; is_fireboy = 1; is_water = 1;
    tick();
    de = 0; is_fireboy = 0; is_water = 0; fireboy_data = 8'h44;
    tick();
    fireboy_data = 0; Reset = 1;
    repeat (2) tick();
    Reset = 0;
    tick();
    check("rst_rgb_zero", {8'h00, Red, Green, Blue}, 32'h0);
    fedge();
    check("rst_discards_hit", fb_obs, fb0);

`ifdef COMPOSITOR_FLASH_EN
    pix(1, 8'h05, 0, 8'h00, 8'h00, 1, 1, 0, 24'h0, "flash_arm", 0);
    fedge();
    for (int f = 1; f <= 10; f++) begin
      pix(1, 8'h05, 0, 8'h00, 8'h00, 1, 0, 0,
          ((f % 2 == 0) && (f <= 8)) ? 24'hFFFFFF : 24'hFF8000, "flash_frame", 1);
      fedge();
    end
`endif

    // Randomized traffic; the per-cycle model checks everything.
    for (int n = 0; n < 2500; n++) begin
      Reset        = ($urandom_range(0, 199) == 0);
      frame_clk    = ((n / 60) % 2) == 1;
      de           = ($urandom_range(0, 7) != 0);
      is_fireboy   = $urandom_range(0, 1);
      is_icegirl   = $urandom_range(0, 1);
      is_water     = ($urandom_range(0, 7) == 0);
      is_lava      = ($urandom_range(0, 7) == 0);
      fireboy_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      icegirl_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      bg_data      = 8'($urandom);
      tick();
    end

    Reset = 0; frame_clk = 0; de = 0; is_fireboy = 0; is_icegirl = 0;
    is_water = 0; is_lava = 0;
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
